// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse macro sequencer: macro geometry,
// sequencer state and mode encodings, and a small sizing helper.
package efuse_pkg;

    localparam int EFUSE_BITS = 256;
    localparam int EFUSE_AW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SKIP
    } efuse_seq_st_e;

    typedef enum logic {
        MODE_RD,
        MODE_PG
    } efuse_seq_mode_e;

    // Largest of four timing parameters, used to size the shared timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/efuse_seq_timer.sv
// Load/count/expire down-counter shared by every sequencer state.
// A load of value v makes expired assert v cycles later, so a state
// entered with v = T-1 lasts exactly T cycles.
module efuse_seq_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Reload on state entry, otherwise count down and park at zero.
    // NOTE: state is written with <= under an async active-low reset so every
    // flop in the block updates from pre-edge values, independent of ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/efuse_macro_seq.sv
// Bit-serial timing sequencer for the 256-bit eFuse hard macro.
// The FSM walks one segment bit at a time (SETUP -> PULSE -> HOLD, or a
// single SKIP cycle for unblown program bits). Macro pins, busy and done
// are registered from the current state, so they trail the state register
// by one edge: a start accepted at edge k shows busy after edge k+1.
module efuse_macro_seq
    import efuse_pkg::*;
#(
    parameter int NR    = 64,
    parameter int NW    = 64,
    parameter int T_SU  = 2,
    parameter int T_RD  = 4,
    parameter int T_PGM = 100,
    parameter int T_HLD = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              read_start,
    input  logic [$clog2(EFUSE_BITS/NR)-1:0]  read_sel,
    output logic                              read_done,
    output logic [NR-1:0]                     read_data,
    output logic                              efuse_busy_read,
    input  logic                              write_start,
    input  logic [$clog2(EFUSE_BITS/NW)-1:0]  write_sel,
    input  logic [NW-1:0]                     write_data,
    output logic                              write_done,
    output logic                              efuse_busy_write,
    output logic                              efuse_csb,
    output logic                              efuse_load,
    output logic                              efuse_pgenb,
    output logic                              efuse_strobe,
    output logic [EFUSE_AW-1:0]               efuse_addr,
    input  logic                              efuse_q
);

    localparam int NMAX = (NR > NW) ? NR : NW;
    localparam int IW   = $clog2(NMAX);
    localparam int TMAX = max4(T_SU, T_RD, T_PGM, T_HLD);
    localparam int TW   = $clog2(TMAX + 1);

    efuse_seq_st_e   state;
    efuse_seq_mode_e mode;
    logic [EFUSE_AW-1:0] base_q;
    logic [IW-1:0]       idx;
    logic [NW-1:0]       wdata_q;
    logic [NR-1:0]       rd_shift;
    logic                fin;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;

    logic          accept_rd;
    logic          accept_pg;
    logic          last_bit;
    logic [IW-1:0] idx_nxt;
    logic          next_skip;

    assign accept_rd = (state == ST_IDLE) && read_start;
    assign accept_pg = (state == ST_IDLE) && !read_start && write_start;
    assign last_bit  = (mode == MODE_RD) ? (idx == IW'(NR - 1)) : (idx == IW'(NW - 1));
    assign idx_nxt   = idx + IW'(1);
    assign next_skip = (mode == MODE_PG) && !wdata_q[idx_nxt];

    efuse_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Timer reload on every state entry, with the duration of the state entered.
    // NOTE: both outputs get a default first so no path leaves them unassigned
    // and no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept_rd) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_SU - 1);
                end else if (accept_pg) begin
                    tmr_load = 1'b1;
                    tmr_val  = write_data[0] ? TW'(T_SU - 1) : '0;
                end
            end
            ST_SETUP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = (mode == MODE_RD) ? TW'(T_RD - 1) : TW'(T_PGM - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_HLD - 1);
                end
            end
            ST_HOLD, ST_SKIP: begin
                if (tmr_exp && !last_bit) begin
                    tmr_load = 1'b1;
                    tmr_val  = next_skip ? '0 : TW'(T_SU - 1);
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM plus the registered macro pins, busy/done flags and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            mode             <= MODE_RD;
            base_q           <= '0;
            idx              <= '0;
            wdata_q          <= '0;
            rd_shift         <= '0;
            fin              <= 1'b0;
            read_done        <= 1'b0;
            read_data        <= '0;
            write_done       <= 1'b0;
            efuse_busy_read  <= 1'b0;
            efuse_busy_write <= 1'b0;
            efuse_csb        <= 1'b1;
            efuse_load       <= 1'b0;
            efuse_pgenb      <= 1'b1;
            efuse_strobe     <= 1'b0;
            efuse_addr       <= '0;
        end else begin
            // Pin stage: a straight function of the current state.
            efuse_csb        <= (state == ST_IDLE);
            efuse_busy_read  <= (state != ST_IDLE) && (mode == MODE_RD);
            efuse_busy_write <= (state != ST_IDLE) && (mode == MODE_PG);
            efuse_load       <= (state != ST_IDLE) && (mode == MODE_RD);
            efuse_pgenb      <= !((state != ST_IDLE) && (mode == MODE_PG));
            efuse_strobe     <= (state == ST_PULSE);
            efuse_addr       <= (state == ST_IDLE) ? '0 : base_q + EFUSE_AW'(idx);

            // Done levels drop once an op is under way and rise one edge after
            // the FSM leaves its final bit.
            if (state != ST_IDLE) begin
                read_done  <= 1'b0;
                write_done <= 1'b0;
            end
            if (fin) begin
                fin <= 1'b0;
                if (mode == MODE_RD) begin
                    read_done <= 1'b1;
                    read_data <= rd_shift;
                end else begin
                    write_done <= 1'b1;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (accept_rd) begin
                        mode   <= MODE_RD;
                        base_q <= EFUSE_AW'(read_sel) * EFUSE_AW'(NR);
                        idx    <= '0;
                        state  <= ST_SETUP;
                    end else if (accept_pg) begin
                        mode    <= MODE_PG;
                        base_q  <= EFUSE_AW'(write_sel) * EFUSE_AW'(NW);
                        wdata_q <= write_data;
                        idx     <= '0;
                        state   <= write_data[0] ? ST_SETUP : ST_SKIP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_exp) state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (tmr_exp) state <= ST_HOLD;
                end
                ST_HOLD, ST_SKIP: begin
                    // The strobe pin lags the state by one edge, so its last
                    // high cycle is the first HOLD cycle: sense Q there.
                    if (state == ST_HOLD && efuse_strobe && mode == MODE_RD) begin
                        rd_shift[idx] <= efuse_q;
                    end
                    if (tmr_exp) begin
                        if (last_bit) begin
                            state <= ST_IDLE;
                            fin   <= 1'b1;
                        end else begin
                            idx   <= idx_nxt;
                            state <= next_skip ? ST_SKIP : ST_SETUP;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_macro_seq.sv
// Self-checking bench for efuse_macro_seq with a behavioural fuse array
// driving efuse_q and a scoreboard of expected op results and latencies.
module tb_efuse_macro_seq;

    localparam int T_SU  = 2;
    localparam int T_RD  = 4;
    localparam int T_PGM = 100;
    localparam int T_HLD = 2;
    localparam int RD_LAT = 1 + 64 * (T_SU + T_RD + T_HLD);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_start = 1'b0;
    logic [1:0]  read_sel = '0;
    logic        read_done;
    logic [63:0] read_data;
    logic        efuse_busy_read;
    logic        write_start = 1'b0;
    logic [1:0]  write_sel = '0;
    logic [63:0] write_data = '0;
    logic        write_done;
    logic        efuse_busy_write;
    logic        efuse_csb;
    logic        efuse_load;
    logic        efuse_pgenb;
    logic        efuse_strobe;
    logic [7:0]  efuse_addr;
    logic        efuse_q;

    logic [255:0] fuse_mem = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_rd;
        logic [63:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] addr;
        int         len;
        logic       pgenb;
        logic       load;
    } pulse_t;
    pulse_t pq[$];
    pulse_t cur;
    int     plen = 0;
    logic [255:0] seen = '0;
    int     pgenb_low = 0;
    int     rd_rises = 0;
    logic   rd_done_prev = 1'b0;

    efuse_macro_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .read_start       (read_start),
        .read_sel         (read_sel),
        .read_done        (read_done),
        .read_data        (read_data),
        .efuse_busy_read  (efuse_busy_read),
        .write_start      (write_start),
        .write_sel        (write_sel),
        .write_data       (write_data),
        .write_done       (write_done),
        .efuse_busy_write (efuse_busy_write),
        .efuse_csb        (efuse_csb),
        .efuse_load       (efuse_load),
        .efuse_pgenb      (efuse_pgenb),
        .efuse_strobe     (efuse_strobe),
        .efuse_addr       (efuse_addr),
        .efuse_q          (efuse_q)
    );

    always #5 clk = ~clk;

    // Macro model: sense output valid only while strobed in read mode.
    assign efuse_q = efuse_strobe & efuse_load & fuse_mem[efuse_addr];

    // Pin monitor: records each strobe pulse, read-mode addresses, pgenb lows
    // and read_done rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            plen = 0;
            rd_done_prev = 1'b0;
        end else begin
            if (efuse_strobe) begin
                if (plen == 0) begin
                    cur.addr  = efuse_addr;
                    cur.pgenb = efuse_pgenb;
                    cur.load  = efuse_load;
                end
                plen++;
            end else if (plen != 0) begin
                cur.len = plen;
                pq.push_back(cur);
                plen = 0;
            end
            if (!efuse_csb && efuse_load) seen[efuse_addr] = 1'b1;
            if (!efuse_pgenb) pgenb_low++;
            if (read_done && !rd_done_prev) rd_rises++;
            rd_done_prev = read_done;
        end
    end

    task automatic run_op(input bit is_rd, input logic [1:0] sel, input logic [63:0] wd,
                          input bit both, input int inject_at,
                          output int lat, output logic pre_done);
        exp_t e;
        int   n;
        int   busy_bad;
        logic d;
        logic post_done;
        @(negedge clk);
        read_start  = is_rd;
        write_start = !is_rd || both;
        read_sel    = sel;
        write_sel   = sel;
        write_data  = wd;
        e.is_rd = is_rd;
        e.data  = is_rd ? fuse_mem[int'(sel)*64 +: 64] : 64'h0;
        e.lat   = is_rd ? RD_LAT
                        : 1 + $countones(wd) * (T_SU + T_PGM + T_HLD) + (64 - $countones(wd));
        sb.push_back(e);
        @(posedge clk);
        #1;
        read_start  = 1'b0;
        write_start = 1'b0;
        pre_done  = is_rd ? read_done : write_done;
        post_done = 1'bx;
        n = 0;
        d = 1'b0;
        busy_bad = 0;
        while (n < 20000 && !d) begin
            if (inject_at > 0 && n == inject_at) write_start = 1'b1;
            @(posedge clk);
            n++;
            #1;
            write_start = 1'b0;
            d = is_rd ? read_done : write_done;
            if (n == 1) post_done = d;
            if (!d) begin
                if ((is_rd ? efuse_busy_read : efuse_busy_write) !== 1'b1 ||
                    (is_rd ? efuse_busy_write : efuse_busy_read) !== 1'b0 ||
                    efuse_csb !== 1'b0)
                    busy_bad++;
            end
        end
        lat = n;
        e = sb.pop_front();
        checks++;
        if (d !== 1'b1) begin
            failures++;
            $display("FAIL op_timeout: done=%b after %0d cycles, required 1", d, n);
        end
        checks++;
        if (n !== e.lat) begin
            failures++;
            $display("FAIL op_latency: got %0d cycles, required %0d", n, e.lat);
        end
        checks++;
        if (post_done !== 1'b0) begin
            failures++;
            $display("FAIL done_clear: done=%b one cycle after start, required 0", post_done);
        end
        if (e.is_rd) begin
            checks++;
            if (read_data !== e.data) begin
                failures++;
                $display("FAIL read_data: got %h required %h", read_data, e.data);
            end
        end
        checks++;
        if (busy_bad !== 0) begin
            failures++;
            $display("FAIL busy_csb: %0d bad cycles while op active, required 0", busy_bad);
        end
        checks++;
        if ({efuse_busy_read, efuse_busy_write, efuse_csb, efuse_load, efuse_pgenb,
             efuse_strobe, efuse_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL idle_pins: br=%b bw=%b csb=%b load=%b pgenb=%b strobe=%b addr=%h, required 0 0 1 0 1 0 00",
                     efuse_busy_read, efuse_busy_write, efuse_csb, efuse_load, efuse_pgenb,
                     efuse_strobe, efuse_addr);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        checks++;
        if ({efuse_csb, efuse_load, efuse_pgenb, efuse_strobe, efuse_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL %s_pins: csb=%b load=%b pgenb=%b strobe=%b addr=%h, required 1 0 1 0 00",
                     tag, efuse_csb, efuse_load, efuse_pgenb, efuse_strobe, efuse_addr);
        end
        checks++;
        if ({read_done, write_done, efuse_busy_read, efuse_busy_write} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_flags: rd_done=%b wr_done=%b busy_r=%b busy_w=%b, required 0000",
                     tag, read_done, write_done, efuse_busy_read, efuse_busy_write);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_pins("reset_held");
        checks++;
        if (read_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_read_data: got %h required 0", read_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_pins("reset_released");
    endtask

    task automatic test_read();
        int   lat;
        logic pre;
        int   bad;
        fuse_mem = {128{2'b01}};
        pq.delete();
        run_op(1'b1, 2'd2, 64'h0, 1'b0, 0, lat, pre);
        checks++;
        if (read_data !== 64'h5555_5555_5555_5555) begin
            failures++;
            $display("FAIL read_even_pattern: got %h required 5555555555555555", read_data);
        end
        checks++;
        if (pq.size() !== 64) begin
            failures++;
            $display("FAIL read_strobe_count: got %0d required 64", pq.size());
        end
        bad = 0;
        foreach (pq[j]) begin
            if (pq[j].addr !== 8'(128 + j) || pq[j].len !== T_RD ||
                pq[j].load !== 1'b1 || pq[j].pgenb !== 1'b1)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL read_strobes: %0d pulses with wrong addr/width/mode, required 0", bad);
        end
    endtask

    task automatic test_program();
        int   lat;
        logic pre;
        pq.delete();
        run_op(1'b0, 2'd1, 64'h8000_0000_0000_0001, 1'b0, 0, lat, pre);
        checks++;
        if (lat !== 271) begin
            failures++;
            $display("FAIL prog_latency_abs: got %0d required 271", lat);
        end
        checks++;
        if (pq.size() !== 2) begin
            failures++;
            $display("FAIL prog_strobe_count: got %0d required 2", pq.size());
        end else begin
            checks++;
            if (pq[0].addr !== 8'd64 || pq[0].len !== T_PGM || pq[0].pgenb !== 1'b0 ||
                pq[1].addr !== 8'd127 || pq[1].len !== T_PGM || pq[1].pgenb !== 1'b0) begin
                failures++;
                $display("FAIL prog_strobes: a0=%0d l0=%0d p0=%b a1=%0d l1=%0d p1=%b, required 64/100/0 127/100/0",
                         pq[0].addr, pq[0].len, pq[0].pgenb, pq[1].addr, pq[1].len, pq[1].pgenb);
            end
        end
        checks++;
        if (read_data !== 64'h5555_5555_5555_5555) begin
            failures++;
            $display("FAIL read_data_hold: got %h required 5555555555555555", read_data);
        end
    endtask

    task automatic test_arbitration();
        int   lat;
        logic pre;
        fuse_mem = {8{$urandom}};
        pq.delete();
        pgenb_low = 0;
        // Simultaneous starts, plus a stray write_start mid-read.
        run_op(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 100, lat, pre);
        checks++;
        if (write_done !== 1'b0) begin
            failures++;
            $display("FAIL arb_write_done: got %b required 0", write_done);
        end
        checks++;
        if (pgenb_low !== 0) begin
            failures++;
            $display("FAIL arb_pgenb: %0d cycles with pgenb low, required 0", pgenb_low);
        end
        checks++;
        if (pq.size() !== 64) begin
            failures++;
            $display("FAIL arb_strobe_count: got %0d required 64", pq.size());
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic pre;
        fuse_mem = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        seen = '0;
        rd_rises = 0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(posedge clk);
            run_op(1'b1, 2'(s), 64'h0, 1'b0, 0, lat, pre);
            checks++;
            if (pre !== 1'b1) begin
                failures++;
                $display("FAIL b2b_done_at_start[%0d]: got %b required 1", s, pre);
            end
        end
        @(negedge clk);
        checks++;
        if (rd_rises !== 4) begin
            failures++;
            $display("FAIL b2b_done_rises: got %0d required 4", rd_rises);
        end
        checks++;
        if (seen !== {256{1'b1}}) begin
            failures++;
            $display("FAIL b2b_addr_cover: %0d of 256 addresses visited", $countones(seen));
        end
    endtask

    task automatic test_reset_mid_program();
        int   cnt;
        int   guard;
        int   lat;
        logic pre;
        @(negedge clk);
        write_start = 1'b1;
        write_sel   = 2'd0;
        write_data  = '1;
        @(posedge clk);
        #1;
        write_start = 1'b0;
        cnt = 0;
        guard = 0;
        while (cnt < 50 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (efuse_strobe) cnt++;
        end
        checks++;
        if (cnt !== 50) begin
            failures++;
            $display("FAIL midrst_wait: saw %0d strobe cycles, required 50", cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({efuse_strobe, efuse_pgenb, efuse_csb, efuse_busy_write} !== 4'b0110) begin
            failures++;
            $display("FAIL midrst_async: strobe=%b pgenb=%b csb=%b busy_w=%b, required 0 1 1 0",
                     efuse_strobe, efuse_pgenb, efuse_csb, efuse_busy_write);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_pins("midrst_after");
        // A fresh read must be accepted immediately and run to full length.
        run_op(1'b1, 2'd3, 64'h0, 1'b0, 0, lat, pre);
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_program();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/efuse_macro_seq.md
Name: efuse_macro_seq

Overview:
- Timing sequencer between efuse_rw_ctrl and the 256-bit eFuse hard macro.
- Accepts segment-level read/program requests (read_start/write_start plus segment select) and generates bit-serial macro pin waveforms: CSB, LOAD, PGENB, STROBE, ADDR.
- Returns read data, sticky done levels and busy flags to efuse_rw_ctrl.
- Pulse widths are cycle-count parameters sized for the macro datasheet at the system clock.

Parameters:
- NR, 64: read segment width in bits; 256 % NR == 0.
- NW, 64: program segment width in bits; 256 % NW == 0.
- T_SU, 2: cycles ADDR/LOAD/PGENB are stable before STROBE rises (≥1).
- T_RD, 4: read STROBE high width in cycles (≥1).
- T_PGM, 100: program STROBE high width in cycles (≥1).
- T_HLD, 2: cycles after STROBE falls before ADDR changes (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- read_start  in  1  read request pulse.
- read_sel  in  $clog2(256/NR)  read segment index.
- read_done  out  1  sticky read-complete level.
- read_data  out  NR  segment read result.
- efuse_busy_read  out  1  read in progress.
- write_start  in  1  program request pulse.
- write_sel  in  $clog2(256/NW)  program segment index.
- write_data  in  NW  bits to blow (1 = blow).
- write_done  out  1  sticky program-complete level.
- efuse_busy_write  out  1  program in progress.
- efuse_csb  out  1  macro chip select, active low.
- efuse_load  out  1  macro read mode.
- efuse_pgenb  out  1  macro program enable, active low.
- efuse_strobe  out  1  macro strobe.
- efuse_addr  out  8  macro bit address.
- efuse_q  in  1  macro sense output, valid while STROBE is high in read mode.

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values of every output:
  - read_done=0, read_data=0, write_done=0, busy flags=0.
  - efuse_csb=1, efuse_load=0, efuse_pgenb=1, efuse_strobe=0, efuse_addr=0.
  - All macro outputs are registered.
- FSM states: IDLE, SETUP, PULSE, HOLD, SKIP. A mode flag (RD/PG) is latched at accept.
- Accept, at edge k:
  - Only in IDLE. If read_start=1, a read is accepted and read_start wins over a simultaneous write_start (write ignored). Otherwise write_start=1 accepts a program.
  - At accept, latch sel, write_data and the mode; clear bit index i=0 and both done flags.
  - Starts in any non-IDLE state are ignored.
- Busy: from k+1, the matching busy flag is 1 and efuse_csb=0 until the op returns to IDLE.
- Read mode: efuse_load=1, efuse_pgenb=1.
- Program mode: efuse_load=0, efuse_pgenb=0.
- Addressing: efuse_addr = sel*NR + i (read) or sel*NW + i (program), computed 8-bit; i counts 0..N-1, LSB first.
- Per-bit sequence:
  - SETUP lasts T_SU cycles, then PULSE (strobe=1) for T_RD (read) or T_PGM (program) cycles, then HOLD for T_HLD cycles.
  - HOLD then advances i, or ends the op after bit N-1.
- Read capture: efuse_q is sampled on the last PULSE cycle into an internal shift register at bit i.
- Program skip: a bit with write_data[i]=0 takes one SKIP cycle with no strobe.
- Completion: on the edge leaving the last HOLD/SKIP:
  - state goes to IDLE; csb=1, load=0, pgenb=1, addr=0; busy=0.
  - The done flag is set. On read, read_data is loaded from the shift register in the same edge.
  - read_data holds until the next read completes.
- Latency from accept edge k to done:
  - Read: done=1 after edge k+1+NR*(T_SU+T_RD+T_HLD). Defaults give k+513.
  - Program: k+1+ones*(T_SU+T_PGM+T_HLD)+zeros.
- Done flags are levels: high until the next accepted start of either kind, cleared at edge k+1. This gives efuse_rw_ctrl a fresh rising edge per read.
- The timer is a single down-counter sized $clog2(max(T_SU,T_RD,T_PGM,T_HLD)+1), reloaded on each state entry.
- Reset mid-operation: all outputs return to reset values immediately (strobe drops asynchronously). The partial read is discarded and no done is raised.

Decomposition:
- efuse_pkg holds:
  - EFUSE_BITS=256 and EFUSE_AW=8.
  - the state enum efuse_seq_st_e.
  - the mode enum efuse_seq_mode_e.
- One sub-module, efuse_seq_timer: load/count/expire down-counter, shared by all states.

Test Plan:
- Reset: hold rst_n=0 then release -> csb=1, pgenb=1, strobe=0, addr=0, read_done=0, write_done=0, busy flags=0.
- Read, read_sel=2, macro model returns Q=1 on even addresses, defaults:
  - addr steps 128..191, 64 strobes of 4 cycles each.
  - read_data=64'h5555_5555_5555_5555; read_done rises at k+513.
  - efuse_busy_read=1 over k+1..k+512.
- Program, write_sel=1, write_data=64'h8000_0000_0000_0001:
  - strobes only at addr 64 and 127, each 100 cycles with pgenb=0.
  - write_done rises at k+1+2*104+62 = k+271.
- Arbitration: read_start and write_start together in IDLE -> read only. write_start during a read -> ignored; pgenb stays 1 throughout.
- Back-to-back: four reads sel 0..3, each issued 2 cycles after read_done rises -> read_done falls one cycle after each start and rises 4 times; addresses cover 0..255.
- Reset mid-program: rst_n=0 at cycle 50 of PULSE -> strobe=0, pgenb=1, csb=1 in the same cycle. After release, write_done=0 and the FSM is in IDLE.
